// File: rtl/seg7_scan_if.sv
// seg7_scan_if
//   Bundles the digit/control load bus and the display pin outputs of
//   seg7_scan_driver so the driver and its user share one connection.
//   load      : 1-cycle strobe capturing the *_in buses
//   digits_in : 4-bit hex value per digit, digit i = [4i+3:4i]
//   dp_in     : decimal point on, per digit
//   en_in     : digit enable (0 = dark)
//   blink_in  : digit blinks when set
//   load_ack  : 1-cycle pulse when a load is committed to the display
//   an        : anode selects, active low
//   seg       : {g,f,e,d,c,b,a}, active low
//   dp        : decimal point, active low
//   slot_idx  : digit index currently scanned
//   Modports: master = bus user (drives loads), slave = display driver.
interface seg7_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
) ();
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    load_ack;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [2:0]              slot_idx;

    modport master (
        output load, digits_in, dp_in, en_in, blink_in,
        input  load_ack, an, seg, dp, slot_idx
    );

    modport slave (
        input  load, digits_in, dp_in, en_in, blink_in,
        output load_ack, an, seg, dp, slot_idx
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a multiplexed common-anode 7-segment bank. A load strobe captures
//   the digit/control buses into a pending buffer, which is committed to the
//   active buffer only at a slot boundary so a digit never changes mid-slot.
//   Each digit slot starts with a blanking dead time to avoid ghosting;
//   blinking digits are darkened during blink phase 1. All pins registered.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     bus  : seg7_scan_if.slave (load bus in, an/seg/dp/slot_idx/load_ack out)
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_CNT = 100_000,
    parameter int unsigned BLANK_CNT   = 1_000,
    parameter int unsigned BLINK_CNT   = 25_000_000
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);

    localparam int unsigned CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int unsigned BLK_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CNT);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
        logic [NUM_DIGITS-1:0]   blink;
    } disp_buf_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    disp_buf_t             pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    disp_buf_t             act_q, act_d;
    logic                  load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [2:0]            slot_idx_q, slot_idx_d;

    logic [3:0] sel_digit;
    logic       sel_dp;
    logic       sel_en;
    logic       sel_blink;

    // Active-buffer fields of the digit currently being scanned.
    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_en    = 1'b0;
        sel_blink = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_digit = act_q.digits[4*i +: 4];
                sel_dp    = act_q.dp[i];
                sel_en    = act_q.en[i];
                sel_blink = act_q.blink[i];
            end
        end
    end

    always_comb begin
        logic boundary;
        logic blink_wrap;
        logic commit;
        logic lit;

        boundary   = (cnt_q == CNT_LAST);
        blink_wrap = (blink_cnt_q == BLK_LAST);
        commit     = boundary & pend_valid_q;

        cnt_d = boundary ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (boundary) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;

        // A load on the commit cycle: the old pending data goes active while
        // the new data is captured and stays pending for the next boundary.
        act_d        = commit ? pend_q : act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q & ~commit;
        if (bus.load) begin
            pend_d.digits = bus.digits_in;
            pend_d.dp     = bus.dp_in;
            pend_d.en     = bus.en_in;
            pend_d.blink  = bus.blink_in;
            pend_valid_d  = 1'b1;
        end
        load_ack_d = commit;

        an_d       = '1;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        slot_idx_d = 3'(idx_q);
        lit        = sel_en & ~(sel_blink & blink_phase_q);
        if ((cnt_q >= BLANK_END) && lit) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
            seg_d = hex_to_seg(sel_digit);
            dp_d  = ~sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            act_q         <= '0;
            load_ack_q    <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            slot_idx_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            act_q         <= act_d;
            load_ack_q    <= load_ack_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            slot_idx_q    <= slot_idx_d;
        end
    end

    assign bus.load_ack = load_ack_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.slot_idx = slot_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver with a small display configuration.
//   The driver process issues one cycle of stimulus at a time and pushes the
//   pin values expected after the coming edge; the monitor pops and compares
//   on every falling edge. Expected values come from a cycle-indexed model:
//   slot counter, digit index and blink phase are derived arithmetically from
//   the number of cycles since reset.
module tb_seg7_scan_driver;

    localparam int unsigned N  = 4;
    localparam int unsigned R  = 8;
    localparam int unsigned BL = 2;
    localparam int unsigned BK = 32;

    typedef struct packed {
        logic [4*N-1:0] digits;
        logic [N-1:0]   dp;
        logic [N-1:0]   en;
        logic [N-1:0]   blink;
    } buf_t;

    typedef struct packed {
        logic         ack;
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic [2:0]   slot;
    } obs_t;

    logic clk;
    logic rst;

    seg7_scan_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .REFRESH_CNT(R),
        .BLANK_CNT  (BL),
        .BLINK_CNT  (BK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    obs_t        exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned acks_seen = 0;
    int unsigned acks_expected = 0;

    // Model state
    int unsigned k = 0;
    buf_t        m_act;
    buf_t        m_pend;
    bit          m_pvalid;

    function automatic obs_t reset_obs();
        obs_t o;
        o.ack  = 1'b0;
        o.an   = '1;
        o.seg  = 7'h7F;
        o.dp   = 1'b1;
        o.slot = 3'd0;
        return o;
    endfunction

    // Pins expected in the cycle after cycle kk, given the buffer shown in kk.
    function automatic obs_t expect_out(int unsigned kk, buf_t a, bit ack);
        obs_t        o;
        int unsigned cnt, idx, ph;
        logic [3:0]  dig;
        cnt    = kk % R;
        idx    = (kk / R) % N;
        ph     = (kk / BK) % 2;
        o      = reset_obs();
        o.ack  = ack;
        o.slot = 3'(idx);
        if (cnt >= BL && a.en[idx] && !(a.blink[idx] && ph == 1)) begin
            for (int i = 0; i < int'(N); i++) o.an[i] = (i != int'(idx));
            dig   = a.digits[4*idx +: 4];
            o.seg = hex_tbl[dig];
            o.dp  = ~a.dp[idx];
        end
        return o;
    endfunction

    task automatic check_eq(input string name, input int unsigned act, input int unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // One cycle of stimulus; called just after a rising edge.
    task automatic step(input bit r, input bit ld, input buf_t d);
        bit ack;
        rst           = r;
        bus.load      = ld;
        bus.digits_in = d.digits;
        bus.dp_in     = d.dp;
        bus.en_in     = d.en;
        bus.blink_in  = d.blink;
        if (r) begin
            exp_q.push_back(reset_obs());
            m_act    = '0;
            m_pend   = '0;
            m_pvalid = 1'b0;
            k        = 0;
        end else begin
            ack = (k % R == R - 1) && m_pvalid;
            exp_q.push_back(expect_out(k, m_act, ack));
            if (ack) begin
                m_act    = m_pend;
                m_pvalid = 1'b0;
                acks_expected++;
            end
            if (ld) begin
                m_pend   = d;
                m_pvalid = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic buf_t rand_buf();
        buf_t b;
        b.digits = 16'($urandom);
        b.dp     = 4'($urandom);
        b.en     = 4'($urandom);
        b.blink  = 4'($urandom);
        return b;
    endfunction

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, rand_buf());
    endtask

    // Idle until the current cycle has the given slot-counter value.
    task automatic idle_until(input int unsigned c);
        for (int unsigned i = 0; i < R && (k % R) != c; i++) step(1'b0, 1'b0, rand_buf());
    endtask

    function automatic buf_t mk(input logic [15:0] dg, input logic [3:0] dpv,
                                input logic [3:0] env, input logic [3:0] blv);
        buf_t b;
        b.digits = dg;
        b.dp     = dpv;
        b.en     = env;
        b.blink  = blv;
        return b;
    endfunction

    // Monitor: pops one expectation per cycle and compares all pins.
    always @(negedge clk) begin
        obs_t e, a;
        a = {bus.load_ack, bus.an, bus.seg, bus.dp, bus.slot_idx};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL pins t=%0t actual ack=%b an=%h seg=%h dp=%b slot=%0d required ack=%b an=%h seg=%h dp=%b slot=%0d",
                          $time, a.ack, a.an, a.seg, a.dp, a.slot, e.ack, e.an, e.seg, e.dp, e.slot);
            n_total++;
            if ($countones(~bus.an) <= 1) n_pass++;
            else $display("FAIL one_anode t=%0t actual an=%b required at most one low bit", $time, bus.an);
            if (bus.load_ack === 1'b1) acks_seen++;
        end
    end

    initial begin
        int unsigned a0;
        m_act    = '0;
        m_pend   = '0;
        m_pvalid = 1'b0;

        // Scenario 1: reset then no load, display dark, slot index scanning.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(200);

        // Scenario 2: a single load of 3210, all enabled.
        a0 = acks_seen;
        step(1'b0, 1'b1, mk(16'h3210, 4'h0, 4'hF, 4'h0));
        idle(5 * R);
        check_eq("single_load_acks", acks_seen - a0, 1);

        // Scenario 3a: two loads in one slot, latest wins, one ack.
        idle_until(1);
        a0 = acks_seen;
        step(1'b0, 1'b1, mk(16'h321A, 4'h0, 4'hF, 4'h0));
        step(1'b0, 1'b1, mk(16'h321F, 4'h0, 4'hF, 4'h0));
        idle(4 * R);
        check_eq("double_load_acks", acks_seen - a0, 1);

        // Scenario 3b: second load on the boundary cycle, two acks.
        idle_until(3);
        a0 = acks_seen;
        step(1'b0, 1'b1, mk(16'h4567, 4'h1, 4'hF, 4'h0));
        idle_until(R - 1);
        step(1'b0, 1'b1, mk(16'h89AB, 4'h2, 4'hF, 4'h0));
        idle(3 * R);
        check_eq("boundary_load_acks", acks_seen - a0, 2);

        // Scenario 4: digit 0 blinks.
        step(1'b0, 1'b1, mk(16'hCDEF, 4'h0, 4'hF, 4'b0001));
        idle(4 * BK);

        // Scenario 5: only digits 0 and 2 enabled, decimal point on digit 2.
        step(1'b0, 1'b1, mk(16'h7654, 4'b0100, 4'b0101, 4'h0));
        idle(3 * N * R);

        // Scenario 6: reset mid-slot while lit, then dark with no acks.
        step(1'b0, 1'b1, mk(16'h8888, 4'hF, 4'hF, 4'h0));
        idle(2 * R);
        idle_until(4);
        step(1'b1, 1'b0, rand_buf());
        a0 = acks_seen;
        idle(3 * N * R);
        check_eq("post_reset_acks", acks_seen - a0, 0);

        // Random traffic with occasional resets.
        for (int unsigned i = 0; i < 2500; i++) begin
            if ($urandom_range(199) == 0)       step(1'b1, 1'b0, rand_buf());
            else if ($urandom_range(11) == 0)   step(1'b0, 1'b1, rand_buf());
            else                                step(1'b0, 1'b0, rand_buf());
        end
        idle(2);
        @(negedge clk);
        #1;
        check_eq("total_acks", acks_seen, acks_expected);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
